// File: rtl/ahb_timer.sv
// AHB-Lite timer peripheral: prescaled 32-bit up-counter with compare match,
// optional auto-reload, sticky pending flag and level interrupt.
module ahb_timer #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel_i,
    input  logic                  hwrite_i,
    input  logic                  hready_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [1:0]            htrans_i,
    input  logic [HADDR_SIZE-1:0] haddr_i,
    input  logic [HDATA_SIZE-1:0] hwdata_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [HDATA_SIZE-1:0] hrdata_o,
    output logic                  timer_irq_o
);

    localparam int unsigned DW = HDATA_SIZE;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_COUNT  = 3'd1;
    localparam logic [2:0] OFF_CMP    = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    typedef enum logic [1:0] {
        RESP_OKAY = 2'd0,
        RESP_ERR1 = 2'd1,
        RESP_ERR2 = 2'd2
    } resp_e;

    resp_e         r_resp;
    logic          r_hreadyout;
    logic          r_hresp;

    logic          r_valid;
    logic          r_write;
    logic          r_err;
    logic [2:0]    r_off;

    logic          r_en;
    logic          r_irq_en;
    logic          r_auto;
    logic          r_pend;
    logic [DW-1:0] r_count;
    logic [DW-1:0] r_cmp;
    logic [DW-1:0] r_presc;
    logic [DW-1:0] r_pcnt;

    logic          w_capture;
    logic          w_addr_err;
    logic          w_wr;
    logic          w_wr_ctrl;
    logic          w_wr_count;
    logic          w_wr_cmp;
    logic          w_wr_status;
    logic          w_wr_presc;
    logic          w_tick;
    logic          w_match;
    logic [DW-1:0] w_rdata;
    logic          w_unused;

    assign w_capture  = hsel_i & hready_i & htrans_i[1];
    assign w_addr_err = (hsize_i != 3'b010) || (haddr_i[4:2] > OFF_PRESC);

    assign w_wr        = r_valid & r_write & ~r_err;
    assign w_wr_ctrl   = w_wr && (r_off == OFF_CTRL);
    assign w_wr_count  = w_wr && (r_off == OFF_COUNT);
    assign w_wr_cmp    = w_wr && (r_off == OFF_CMP);
    assign w_wr_status = w_wr && (r_off == OFF_STATUS);
    assign w_wr_presc  = w_wr && (r_off == OFF_PRESC);

    assign w_tick  = r_en && (r_pcnt == r_presc);
    assign w_match = w_tick && (r_count == r_cmp);

    assign w_unused = &{1'b0, hburst_i, htrans_i[0], haddr_i[HADDR_SIZE-1:5], haddr_i[1:0]};

    // Address-phase capture and error response sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_off       <= 3'd0;
            r_resp      <= RESP_OKAY;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            r_valid <= w_capture;
            r_write <= w_capture & hwrite_i;
            r_err   <= w_capture & w_addr_err;
            r_off   <= w_capture ? haddr_i[4:2] : 3'd0;
            case (r_resp)
                RESP_ERR1: begin
                    r_resp      <= RESP_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    if (w_capture && w_addr_err) begin
                        r_resp      <= RESP_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                    end else begin
                        r_resp      <= RESP_OKAY;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Control and compare registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_auto   <= 1'b0;
            r_cmp    <= '1;
            r_presc  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= hwdata_i[0];
                r_irq_en <= hwdata_i[1];
                r_auto   <= hwdata_i[2];
            end
            if (w_wr_cmp) begin
                r_cmp <= hwdata_i;
            end
            if (w_wr_presc) begin
                r_presc <= hwdata_i;
            end
        end
    end

    // Prescaler, counter and pending flag; bus write beats the tick, the
    // hardware set beats the W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt  <= '0;
            r_count <= '0;
            r_pend  <= 1'b0;
        end else begin
            if (!r_en || w_wr_presc || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + DW'(1);
            end

            if (w_wr_count) begin
                r_count <= hwdata_i;
            end else if (w_tick) begin
                r_count <= (w_match && r_auto) ? '0 : r_count + DW'(1);
            end

            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_wr_status && hwdata_i[0]) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_valid && !r_write && !r_err) begin
            case (r_off)
                OFF_CTRL:   w_rdata = {{(DW-3){1'b0}}, r_auto, r_irq_en, r_en};
                OFF_COUNT:  w_rdata = r_count;
                OFF_CMP:    w_rdata = r_cmp;
                OFF_STATUS: w_rdata = {{(DW-1){1'b0}}, r_pend};
                OFF_PRESC:  w_rdata = r_presc;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign hreadyout_o = r_hreadyout;
    assign hresp_o     = r_hresp;
    assign hrdata_o    = w_rdata;
    assign timer_irq_o = r_pend & r_irq_en;

endmodule

// File: tb/tb_ahb_timer.sv
// Directed bench for ahb_timer: single-slave bus with HREADY looped back,
// hand-computed register, counter, interrupt and error-response values.
module tb_ahb_timer;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_COUNT  = 32'h04;
    localparam logic [31:0] A_CMP    = 32'h08;
    localparam logic [31:0] A_STATUS = 32'h0C;
    localparam logic [31:0] A_PRESC  = 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic        hwrite;
    logic        hready;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hready = hreadyout;

    ahb_timer #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .hsel_i      (hsel),
        .hwrite_i    (hwrite),
        .hready_i    (hready),
        .hsize_i     (hsize),
        .hburst_i    (hburst),
        .htrans_i    (htrans),
        .haddr_i     (haddr),
        .hwdata_i    (hwdata),
        .hreadyout_o (hreadyout),
        .hresp_o     (hresp),
        .hrdata_o    (hrdata),
        .timer_irq_o (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        haddr  = 32'h0;
    endtask

    task automatic addr_ph(input logic w, input logic [31:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = w;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_ph(1'b1, a, 3'b010);
        step();
        bus_idle();
        hwdata = d;
        chk("wr_okay", 32'({hreadyout, hresp}), 32'h2);
        step();
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_ph(1'b0, a, 3'b010);
        step();
        bus_idle();
        chk(tag, hrdata, exp);
        step();
    endtask

    // Write immediately followed by a pipelined read
    task automatic wr_rd(input string tag, input logic [31:0] wa, input logic [31:0] d,
                         input logic [31:0] ra, input logic [31:0] exp);
        addr_ph(1'b1, wa, 3'b010);
        step();
        hwdata = d;
        addr_ph(1'b0, ra, 3'b010);
        step();
        bus_idle();
        chk(tag, hrdata, exp);
        step();
    endtask

    task automatic err_xfer(input string tag, input logic w, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] d);
        addr_ph(w, a, sz);
        step();
        bus_idle();
        hwdata = d;
        chk({tag, "_err1"}, 32'({hreadyout, hresp}), 32'h1);
        chk({tag, "_err1_rdata"}, hrdata, 32'h0);
        step();
        chk({tag, "_err2"}, 32'({hreadyout, hresp}), 32'h3);
        step();
        chk({tag, "_okay"}, 32'({hreadyout, hresp}), 32'h2);
    endtask

    initial begin
        rst    = 1'b1;
        hburst = 3'b000;
        hwdata = 32'h0;
        bus_idle();
        #2;
        chk("rst_out", 32'({hreadyout, hresp, irq}), 32'h4);
        chk("rst_rdata", hrdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_count", A_COUNT, 32'h0);

        // Prescaled count with auto-reload
        wr(A_PRESC, 32'd3);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h7);
        addr_ph(1'b0, A_COUNT, 3'b010);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("auto_count_%0d", k), hrdata, (k < 24) ? 32'(k / 4) : 32'h0);
            chk($sformatf("auto_irq_%0d", k), 32'(irq), (k >= 24) ? 32'h1 : 32'h0);
        end
        bus_idle();
        wr(A_CTRL, 32'h2);
        rd_chk("hold_count", A_COUNT, 32'h0);

        // Pending flag and W1C
        rd_chk("status_pend", A_STATUS, 32'h1);
        chk("irq_pend", 32'(irq), 32'h1);
        wr(A_STATUS, 32'h0);
        rd_chk("status_w0", A_STATUS, 32'h1);
        wr(A_STATUS, 32'h1);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd_chk("status_cleared", A_STATUS, 32'h0);

        // Wrap and match at zero without auto-reload
        wr(A_PRESC, 32'd0);
        wr(A_CMP, 32'd0);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h3);
        addr_ph(1'b0, A_COUNT, 3'b010);
        step();
        chk("wrap_ffff", hrdata, 32'hFFFF_FFFF);
        chk("wrap_irq0", 32'(irq), 32'h0);
        step();
        chk("wrap_zero", hrdata, 32'h0);
        chk("wrap_irq1", 32'(irq), 32'h0);
        step();
        chk("wrap_one", hrdata, 32'h1);
        chk("wrap_irq2", 32'(irq), 32'h1);
        bus_idle();
        wr(A_CTRL, 32'h2);
        rd_chk("wrap_status", A_STATUS, 32'h1);

        // Error responses leave state untouched
        wr(A_COUNT, 32'h55);
        err_xfer("byte_rd", 1'b0, A_COUNT, 3'b000, 32'h0);
        err_xfer("unmapped_wr", 1'b1, 32'h18, 3'b010, 32'hDEAD_BEEF);
        err_xfer("byte_wr", 1'b1, A_COUNT, 3'b000, 32'h77);
        rd_chk("err_ctrl", A_CTRL, 32'h2);
        rd_chk("err_count", A_COUNT, 32'h55);
        rd_chk("err_cmp", A_CMP, 32'h0);
        rd_chk("err_status", A_STATUS, 32'h1);
        rd_chk("err_presc", A_PRESC, 32'h0);

        // Bus write to COUNT on a tick cycle
        wr(A_CTRL, 32'h1);
        wr_rd("count_wr_tick", A_COUNT, 32'h100, A_COUNT, 32'h100);
        wr(A_CTRL, 32'h0);

        // W1C coinciding with a compare match
        wr(A_CMP, 32'h10);
        wr(A_STATUS, 32'h1);
        rd_chk("pre_match_status", A_STATUS, 32'h0);
        wr(A_COUNT, 32'h0E);
        wr(A_CTRL, 32'h3);
        step();
        wr(A_STATUS, 32'h1);
        chk("w1c_vs_match_irq", 32'(irq), 32'h1);
        rd_chk("w1c_vs_match_status", A_STATUS, 32'h1);

        // Back-to-back write then read of CMP
        wr(A_CTRL, 32'h2);
        wr_rd("cmp_b2b", A_CMP, 32'hABCD_1234, A_CMP, 32'hABCD_1234);

        // PRESC write restarts the prescaler
        wr(A_COUNT, 32'h0);
        wr(A_PRESC, 32'd3);
        wr(A_CTRL, 32'h3);
        step();
        wr(A_PRESC, 32'd3);
        addr_ph(1'b0, A_COUNT, 3'b010);
        step();
        chk("presc_clr_a", hrdata, 32'h0);
        step();
        step();
        chk("presc_clr_b", hrdata, 32'h0);
        step();
        chk("presc_clr_c", hrdata, 32'h1);
        bus_idle();
        chk("pre_rst_irq", 32'(irq), 32'h1);

        // Reset during ERR1
        addr_ph(1'b1, 32'h1C, 3'b010);
        step();
        bus_idle();
        chk("rst_err1_pre", 32'({hreadyout, hresp}), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_err1_out", 32'({hreadyout, hresp, irq}), 32'h4);
        chk("rst_err1_rdata", hrdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_okay", 32'({hreadyout, hresp}), 32'h2);
        rd_chk("post_rst_ctrl", A_CTRL, 32'h0);
        rd_chk("post_rst_count", A_COUNT, 32'h0);
        rd_chk("post_rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_chk("post_rst_presc", A_PRESC, 32'h0);
        rd_chk("post_rst_status", A_STATUS, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 The module SHALL have parameter HADDR_SIZE, default 32, meaning the AHB address width.
REQ-002 The module SHALL have parameter HDATA_SIZE, default 32, meaning the AHB data width; only 32 is supported.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port hsel_i, input, 1 bit: slave select from the interconnect.
REQ-006 The module SHALL have port hwrite_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 The module SHALL have port hready_i, input, 1 bit: bus-level HREADY.
REQ-008 The module SHALL have port hsize_i, input, 3 bits: transfer size.
REQ-009 The module SHALL have port hburst_i, input, 3 bits: burst type; accepted and ignored.
REQ-010 The module SHALL have port htrans_i, input, 2 bits: transfer type.
REQ-011 The module SHALL have port haddr_i, input, HADDR_SIZE bits: address; only bits [4:2] are decoded.
REQ-012 The module SHALL have port hwdata_i, input, HDATA_SIZE bits: write data, valid in the data phase.
REQ-013 The module SHALL have port hreadyout_o, output, 1 bit: slave ready.
REQ-014 The module SHALL have port hresp_o, output, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-015 The module SHALL have port hrdata_o, output, HDATA_SIZE bits: read data.
REQ-016 The module SHALL have port timer_irq_o, output, 1 bit: level interrupt that drives the core's timer_irq_i.

Function
REQ-017 Register map at word offset haddr_i[4:2]:
- 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
- 0x04 COUNT.
- 0x08 CMP.
- 0x0C STATUS: bit0 PEND, write-1-to-clear.
- 0x10 PRESC.
- 0x14-0x1C are unmapped.
REQ-018 Address-phase capture: when hsel_i & hready_i & htrans_i[1] are all 1, the block SHALL register write, offset and an error flag.
- Error flag = (hsize_i != 3'b010) or unmapped offset.
- In every other cycle the registered transfer is cleared to "no transfer" (IDLE/BUSY).
REQ-019 A non-error transfer SHALL complete with zero wait states: hreadyout_o=1 and hresp_o=0 in its data phase.
REQ-020 A write SHALL sample hwrite_i data (hwdata_i) in the data phase and update the target register on the clock edge ending that phase.
REQ-021 In a read data phase, hrdata_o SHALL show the selected register's current value.
- Outside a read data phase, hrdata_o SHALL be 0.
REQ-022 An error transfer SHALL use a response FSM with states OKAY -> ERR1 -> ERR2 -> OKAY:
- ERR1: hreadyout_o=0, hresp_o=1.
- ERR2: hreadyout_o=1, hresp_o=1.
- Error writes have no effect; error reads return 0.
REQ-023 Prescaler: while EN=1, an internal counter pcnt increments every clk.
- When pcnt==PRESC, pcnt returns to 0 and a one-cycle tick is issued.
- PRESC=0 gives a tick every cycle.
REQ-024 On a tick:
- If COUNT==CMP, PEND is set to 1 and COUNT becomes 0 if AUTO_RELOAD=1, otherwise COUNT+1.
- If COUNT!=CMP, COUNT becomes COUNT+1.
- COUNT wraps from 0xFFFFFFFF to 0.
REQ-025 While EN=0, COUNT SHALL hold and pcnt SHALL be forced to 0.
REQ-026 A bus write to COUNT in the same cycle as a tick SHALL win; the written value is loaded and the increment is dropped.
REQ-027 For STATUS, a hardware PEND set in the same cycle as a W1C write SHALL win; PEND stays 1.
REQ-028 A write to PRESC SHALL also clear pcnt to 0.
REQ-029 timer_irq_o SHALL equal PEND & IRQ_EN, both taken from flops, with no combinational path from bus inputs.

Reset
REQ-030 While rst=1, all registers SHALL be forced asynchronously to their reset values:
- CTRL=0, COUNT=0, CMP=0xFFFFFFFF, PEND=0, PRESC=0, pcnt=0.
- Response FSM = OKAY; registered transfer = none.
- Outputs: hreadyout_o=1, hresp_o=0, hrdata_o=0, timer_irq_o=0.
REQ-031 A reset asserted mid-transfer or mid-ERR1 SHALL abort the transfer; the first post-reset cycle is OKAY with no register update.

Verification
REQ-032 Write PRESC=3, CMP=5, CTRL=0x7 -> COUNT increments every 4 cycles 0..5; PEND and timer_irq_o rise on the tick at COUNT==5; COUNT returns to 0.
REQ-033 Read STATUS after the irq -> 0x1; write STATUS=0x1 -> PEND=0 and timer_irq_o=0 the next cycle; write 0x0 leaves PEND unchanged.
REQ-034 AUTO_RELOAD=0, COUNT=0xFFFFFFFE, CMP=0, PRESC=0, EN=1 -> COUNT goes 0xFFFFFFFF, then 0; PEND is set on the tick at COUNT==0.
REQ-035 Byte read (hsize_i=0) of 0x04, and word write to 0x18 -> ERR1 then ERR2 (hreadyout_o 0 then 1, hresp_o 1 both cycles); COUNT and all registers unchanged.
REQ-036 Simultaneous events:
- Bus write COUNT=0x100 on a tick cycle -> COUNT=0x100.
- W1C on the same cycle as a compare match -> PEND=1.
REQ-037 Back-to-back writes CMP then a read of CMP, with zero wait states -> the read returns the new value; rst pulsed during ERR1 -> outputs return to reset values immediately.
